// File: rtl/cmp_pkg.sv
// ============================================================================
// Module : cmp_pkg
// Brief  : Shared encodings for the comparison scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_GT  = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b10;
  localparam logic [1:0] CMP_MAX = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cmp_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker, searching upward from ptr+1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW:0] cand;

  // Sum stays below 2*NREQ, so one conditional subtract gives the modulo.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!any_o && req_i[cand[IDXW-1:0]]) begin
        any_o                    = 1'b1;
        idx_o                    = cand[IDXW-1:0];
        grant_o[cand[IDXW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmp_scheduler.sv
// ============================================================================
// Module : cmp_scheduler
// Brief  : Round-robin sharing of one 4-bit comparison unit among requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cmp_scheduler
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_sel,
  input  logic [8*NREQ-1:0] req_z,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [3:0]        rsp_result,
  output logic [1:0]        cmp_select,
  output logic [7:0]        cmp_z,
  input  logic [3:0]        cmp_result,
  output logic              busy,
  output logic [CNTW-1:0]   ops_done
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        z_q, z_d;
  logic [3:0]        res_q, res_d;
  logic [NREQ-1:0]   rspv_q, rspv_d;
  logic [CNTW-1:0]   ops_q, ops_d;

  logic [NREQ-1:0]   arb_grant;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_any;

  logic [1:0]        w_sel [NREQ];
  logic [7:0]        w_z   [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_sel[g] = req_sel[2*g +: 2];
    assign w_z[g]   = req_z[8*g +: 8];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    sel_d     = sel_q;
    z_d       = z_q;
    res_d     = res_q;
    rspv_d    = rspv_q;
    ops_d     = ops_q;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          sel_d   = w_sel[arb_idx];
          z_d     = w_z[arb_idx];
          owner_d = arb_idx;
          ptr_d   = arb_idx;
          state_d = S_DRIVE;
        end
      end
      // Comparison inputs have been registered for a full cycle here.
      S_DRIVE: begin
        res_d   = cmp_result;
        rspv_d  = NREQ'(1) << owner_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          rspv_d  = '0;
          ops_d   = ops_q + CNTW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDXW'(NREQ - 1);
      owner_q <= '0;
      sel_q   <= '0;
      z_q     <= '0;
      res_q   <= '0;
      rspv_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      z_q     <= z_d;
      res_q   <= res_d;
      rspv_q  <= rspv_d;
      ops_q   <= ops_d;
    end
  end

  assign cmp_select = sel_q;
  assign cmp_z      = z_q;
  assign rsp_result = res_q;
  assign rsp_valid  = rspv_q;
  assign ops_done   = ops_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmp_scheduler.sv
// ============================================================================
// Module : tb_cmp_scheduler
// Brief  : Directed plus random checking of cmp_scheduler against a
//          transaction-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cmp_scheduler;

  localparam int NREQ = 4;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_sel;
  logic [8*NREQ-1:0] req_z;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [3:0]        rsp_result;
  logic [1:0]        cmp_select;
  logic [7:0]        cmp_z;
  logic [3:0]        cmp_result;
  logic              busy;
  logic [CNTW-1:0]   ops_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase 0 = free, 1 = computing, 2 = awaiting response.
  int         m_phase;
  int         m_ptr;
  int         m_owner;
  int         m_ops;
  logic [1:0] m_sel;
  logic [7:0] m_z;
  logic [3:0] m_res;

  cmp_scheduler #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_z      (req_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .cmp_select (cmp_select),
    .cmp_z      (cmp_z),
    .cmp_result (cmp_result),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_cmp(input logic [1:0] sel, input logic [7:0] z);
    int x, y;
    x = int'(z[3:0]);
    y = int'(z[7:4]);
    case (sel)
      2'd0:    return (x == y) ? 4'd1 : 4'd0;
      2'd1:    return (x > y)  ? 4'd1 : 4'd0;
      2'd2:    return (x < y)  ? 4'd1 : 4'd0;
      default: return (x > y)  ? z[3:0] : z[7:4];
    endcase
  endfunction

  always_comb cmp_result = ref_cmp(cmp_select, cmp_z);

  function automatic int winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = NREQ - 1; m_owner = 0; m_ops = 0;
    m_sel = '0; m_z = '0; m_res = '0;
  endtask

  // Applies inputs for one cycle, checks outputs mid-cycle, advances the model.
  task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [2*NREQ-1:0] sel,
                             input logic [8*NREQ-1:0] z, input logic [NREQ-1:0] rr);
    int w;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    req_valid = v; req_sel = sel; req_z = z; rsp_ready = rr;
    #4;
    w       = winner(v, m_ptr);
    exp_rdy = (m_phase == 0 && w >= 0) ? NREQ'(1) << w : '0;
    exp_rv  = (m_phase == 2) ? NREQ'(1) << m_owner : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    chk("ops_done", 32'(ops_done), 32'(m_ops));
    chk("cmp_select", 32'(cmp_select), 32'(m_sel));
    chk("cmp_z", 32'(cmp_z), 32'(m_z));
    if (m_phase == 2) chk("rsp_result", 32'(rsp_result), 32'(m_res));
    case (m_phase)
      0: if (w >= 0) begin
           m_owner = w; m_ptr = w;
           m_sel = sel[2*w +: 2]; m_z = z[8*w +: 8];
           m_phase = 1;
         end
      1: begin m_res = ref_cmp(m_sel, m_z); m_phase = 2; end
      default: if (rr[m_owner]) begin m_ops = (m_ops + 1) % (1 << CNTW); m_phase = 0; end
    endcase
    @(posedge clk); #1;
  endtask

  // One complete operation for requester r with immediate response accept.
  task automatic one_op(input int r, input logic [1:0] sel, input logic [7:0] z,
                        input logic [3:0] exp_res);
    logic [2*NREQ-1:0] sv;
    logic [8*NREQ-1:0] zv;
    sv = {NREQ{sel}};
    zv = {NREQ{z}};
    drive_cycle(NREQ'(1) << r, sv, zv, '0);
    drive_cycle('0, sv, zv, '0);
    chk("plan_result", 32'(rsp_result), 32'(exp_res));
    drive_cycle('0, sv, zv, '1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_sel = '0; req_z = '0; rsp_ready = '0;
    model_reset();
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin from reset: grants 0,1,2,3,0.
    for (int c = 0; c < 15; c++) drive_cycle('1, $urandom, {$urandom, $urandom}, '1);

    // Single op and the flag ops.
    one_op(0, 2'b11, 8'h5A, 4'hA);
    one_op(2, 2'b00, 8'h33, 4'h1);
    one_op(2, 2'b01, 8'h33, 4'h0);
    one_op(2, 2'b10, 8'h33, 4'h0);
    one_op(2, 2'b10, 8'h73, 4'h1);

    // Backpressure on requester 1; non-owner ready bits must be ignored.
    drive_cycle(4'b0010, $urandom, {$urandom, $urandom}, '0);
    for (int c = 0; c < 6; c++) drive_cycle('1, $urandom, {$urandom, $urandom}, 4'b1101);
    drive_cycle('0, '0, '0, 4'b0010);
    drive_cycle('0, '0, '0, '0);

    // Reset while the operation is in DRIVE.
    drive_cycle(4'b0010, 8'hFF, {4{8'h21}}, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_cmp_z", 32'(cmp_z), 0);
    chk("midrst_ops_done", 32'(ops_done), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(4'b1001, 8'h00, {4{8'h44}}, '1);
    drive_cycle('0, '0, '0, '1);
    drive_cycle('0, '0, '0, '1);

    // Counter wrap: one completion above plus fifteen more returns to zero.
    for (int n = 0; n < 15; n++) begin
      logic [1:0] s;
      logic [7:0] z;
      s = 2'($urandom);
      z = 8'($urandom);
      one_op(n % NREQ, s, z, ref_cmp(s, z));
    end
    chk("wrap", 32'(ops_done), 0);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      logic [NREQ-1:0] v, rr;
      v  = NREQ'($urandom) & NREQ'($urandom);
      rr = NREQ'($urandom) | NREQ'($urandom);
      drive_cycle(v, $urandom, {$urandom, $urandom}, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
